rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Hardware rectangle-fill engine on the write port (port A) of the dual-port framebuffer. It takes a screen-space rectangle and a colour, clips the rectangle to the screen, and writes the colour to every covered pixel, one pixel per granted cycle, in row-major order. It sits upstream of the framebuffer, in parallel with the CPU write path. An external arbiter hands it the port through `grant`.

## Interface
- `WIDTH`, 9: pixel width in bits; matches the framebuffer data width.
- `DEPTH`, 2048: framebuffer depth in pixels; must be ≥ `SCREEN_W*SCREEN_H`.
- `SCREEN_W`, 64: screen width in pixels; power of two.
- `SCREEN_H`, 32: screen height in pixels; power of two.
- Derived widths:
  - `XB = $clog2(SCREEN_W)`
  - `YB = $clog2(SCREEN_H)`
  - `AB = $clog2(DEPTH)`
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `nReset` in 1: asynchronous, active-low reset.
  - `start` in 1: request a fill. Sampled only in IDLE.
  - `x0` in XB: left edge.
  - `y0` in YB: top edge.
  - `rectWidth` in XB+1: width in pixels, 0..SCREEN_W.
  - `rectHeight` in YB+1: height in pixels, 0..SCREEN_H.
  - `colour` in WIDTH: fill value.
  - `grant` in 1: the arbiter gives port A to this block this cycle.
  - `busy` out 1: high in FILL and DONE.
  - `done` out 1: one-cycle pulse at completion.
  - `fbAddress` out AB: to framebuffer `addressA`.
  - `fbData` out WIDTH: to framebuffer `dataInA`.
  - `fbWriteEnable` out 1: to framebuffer `writeEnableA`.

## Operation
- States: IDLE, FILL, DONE.
- **IDLE + `start`** (edge E0):
  - Latch `colour` into `fbData`.
  - Compute the clipped end coordinates in XB+2 / YB+2 bits:
    - `xEnd = min(x0+rectWidth, SCREEN_W)`
    - `yEnd = min(y0+rectHeight, SCREEN_H)`
  - Set the counters `xCur = x0`, `yCur = y0`.
  - If `rectWidth==0`, `rectHeight==0`, or the clipped area is empty, go to DONE. Otherwise go to FILL.
- **FILL**:
  - `fbAddress = yCur*SCREEN_W + xCur` (shift plus concatenation; no multiplier). Registered; updated together with the counters.
  - `fbWriteEnable = (state==FILL) & grant`, combinational from the state register and `grant`.
  - A write is accepted on each edge where `fbWriteEnable` is 1. On acceptance:
    - If `xCur+1 < xEnd`: `xCur++`.
    - Else if `yCur+1 < yEnd`: `xCur = x0` (latched copy), `yCur++`.
    - Else: go to DONE.
  - `grant` low: no write; address, counters and state hold.
- **DONE**:
  - `done=1` and `busy=1` for exactly one cycle, then IDLE.
- `start` while `busy` is ignored and not queued. `x0`/`y0`/`rectWidth`/`rectHeight`/`colour` matter only at E0; later changes have no effect on the fill in progress.
- Reset values (asynchronous, immediate):
  - state IDLE.
  - `busy=0`, `done=0`, `fbWriteEnable=0`.
  - `fbAddress=0`, `fbData=0`.
  - Counters 0.
- Reset mid-fill aborts immediately. No further writes; no `done` pulse.

## Timing
- Latency from `start` (edge E0) to the first write: the write is presented in the cycle after E0 and committed at E1, with `grant` constantly high.
- Throughput: 1 pixel per granted cycle. The last write commits at edge En, where n = number of clipped pixels.
- With `grant` constantly high:
  - `done` is high in cycle n+1 (between En and En+1).
  - `busy` falls at En+1.
  - A new `start` is accepted at En+1 at the earliest.
- Empty rectangle: DONE after E0, `done` high in the next cycle, zero writes.
- Each `grant`-low cycle in FILL extends completion by exactly one cycle.
- The framebuffer's 1-cycle read latency is irrelevant; this block never reads.

## Test plan
- **Basic fill**:
  - Stimulus: defaults, `grant`=1, start with x0=1, y0=1, w=2, h=2, colour=0x1FF.
  - Required: writes at addresses 65, 66, 129, 130 on E1..E4, all data 0x1FF. `done` high in cycle 5, `busy` low after E5.
- **Clipping**:
  - Stimulus: x0=62, y0=31, w=4, h=3, colour=0x0A5.
  - Required: exactly two writes, at 2046 then 2047. `done` follows.
  - Also: full-screen fill (w=64, h=32) gives 2048 writes at addresses 0..2047 in order.
- **Empty rectangle**:
  - Stimulus: w=0, h=5.
  - Required: no `fbWriteEnable` ever. `done` high in the cycle after E0.
- **Grant stall**:
  - Stimulus: 3×1 fill at (0,0), `grant` low in cycles 2–3.
  - Required: address 1 held during the stall. Writes at 0, 1, 2 commit on E1, E4, E5. `done` high in cycle 6.
- **Start while busy**:
  - Stimulus: second `start` with a different colour in cycle 2 of a 4-pixel fill.
  - Required: ignored, and all 4 writes keep the original colour.
- **Async reset mid-fill**:
  - Stimulus: drop `nReset` mid-cycle after 2 writes of a 2×2 fill.
  - Required: `fbWriteEnable` and `busy` go to 0 immediately, with no clock edge. No `done` pulse. A subsequent start behaves as in the basic-fill case.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine for framebuffer write port A: clips a rectangle to the
// screen and writes one colour to every covered pixel in row-major order.
module rect_fill_engine #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 2048,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32,
    localparam int XB = $clog2(SCREEN_W),
    localparam int YB = $clog2(SCREEN_H),
    localparam int AB = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [XB-1:0]    x0,
    input  logic [YB-1:0]    y0,
    input  logic [XB:0]      rectWidth,
    input  logic [YB:0]      rectHeight,
    input  logic [WIDTH-1:0] colour,
    input  logic             grant,
    output logic             busy,
    output logic             done,
    output logic [AB-1:0]    fbAddress,
    output logic [WIDTH-1:0] fbData,
    output logic             fbWriteEnable,
    output logic [1:0]       fillState
);

    // Handshake: a pixel write is accepted on every rising edge where
    // fbWriteEnable (FILL and grant) is high; grant low simply stalls.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XB+1:0] X_ONE   = (XB+2)'(1);
    localparam logic [YB+1:0] Y_ONE   = (YB+2)'(1);
    localparam logic [XB+1:0] X_LIMIT = (XB+2)'(SCREEN_W);
    localparam logic [YB+1:0] Y_LIMIT = (YB+2)'(SCREEN_H);

    state_t        state;
    logic [XB-1:0] xCur;
    logic [XB-1:0] xStart;
    logic [YB-1:0] yCur;
    logic [XB+1:0] xEnd;
    logic [YB+1:0] yEnd;

    logic [XB+1:0] xSum;
    logic [YB+1:0] ySum;
    logic [XB+1:0] xEndNew;
    logic [YB+1:0] yEndNew;
    logic [XB+1:0] xInc;
    logic [YB+1:0] yInc;
    logic          emptyRect;

    function automatic logic [AB-1:0] pixelAddr(input logic [YB-1:0] y, input logic [XB-1:0] x);
        return AB'({y, x});
    endfunction

    always_comb begin
        xSum      = {2'b00, x0} + {1'b0, rectWidth};
        ySum      = {2'b00, y0} + {1'b0, rectHeight};
        xEndNew   = (xSum > X_LIMIT) ? X_LIMIT : xSum;
        yEndNew   = (ySum > Y_LIMIT) ? Y_LIMIT : ySum;
        emptyRect = (rectWidth == '0) || (rectHeight == '0) ||
                    (xEndNew <= {2'b00, x0}) || (yEndNew <= {2'b00, y0});
        xInc      = {2'b00, xCur} + X_ONE;
        yInc      = {2'b00, yCur} + Y_ONE;
    end

    assign fbWriteEnable = (state == FILL) & grant;
    assign fillState     = state;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fbAddress <= '0;
            fbData    <= '0;
            xCur      <= '0;
            yCur      <= '0;
            xStart    <= '0;
            xEnd      <= '0;
            yEnd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        fbData    <= colour;
                        xStart    <= x0;
                        xCur      <= x0;
                        yCur      <= y0;
                        xEnd      <= xEndNew;
                        yEnd      <= yEndNew;
                        fbAddress <= pixelAddr(y0, x0);
                        busy      <= 1'b1;
                        if (emptyRect) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    // Address advances with the counters so it always names the pending pixel.
                    if (grant) begin
                        if (xInc < xEnd) begin
                            xCur      <= xInc[XB-1:0];
                            fbAddress <= pixelAddr(yCur, xInc[XB-1:0]);
                        end else if (yInc < yEnd) begin
                            xCur      <= xStart;
                            yCur      <= yInc[YB-1:0];
                            fbAddress <= pixelAddr(yInc[YB-1:0], xStart);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed and random fills checked against a
// pixel-list model through an expected-write queue.
module tb_rect_fill_engine;

    localparam int DW = 9;
    localparam int AW = 11;
    localparam int W  = AW + DW;

    logic          clk;
    logic          nReset;
    logic          start;
    logic [5:0]    x0;
    logic [4:0]    y0;
    logic [6:0]    rectWidth;
    logic [5:0]    rectHeight;
    logic [DW-1:0] colour;
    logic          grant;
    logic          busy;
    logic          done;
    logic [AW-1:0] fbAddress;
    logic [DW-1:0] fbData;
    logic          fbWriteEnable;
    logic [1:0]    fillState;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int wrCount = 0;

    rect_fill_engine dut (
        .clk(clk), .nReset(nReset), .start(start), .x0(x0), .y0(y0),
        .rectWidth(rectWidth), .rectHeight(rectHeight), .colour(colour),
        .grant(grant), .busy(busy), .done(done), .fbAddress(fbAddress),
        .fbData(fbData), .fbWriteEnable(fbWriteEnable), .fillState(fillState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: enumerate the clipped pixels directly in row-major order.
    task automatic pushModel(input int px, input int py, input int w, input int h,
                             input logic [DW-1:0] col, output int n);
        logic [AW-1:0] a;
        n = 0;
        for (int y = py; y < py + h && y < 32; y++) begin
            for (int x = px; x < px + w && x < 64; x++) begin
                a = AW'(y * 64 + x);
                exp_q.push_back({a, col});
                n++;
            end
        end
    endtask

    // Monitor: every accepted write must match the head of the queue.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (nReset && fbWriteEnable) begin
            wrCount++;
            if (!grant) check("write_without_grant", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(fbAddress), -1);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", int'(fbAddress), int'(e[W-1:DW]));
                check("write_data", int'(fbData), int'(e[DW-1:0]));
            end
        end
    end

    // grantMode: 0 always high, 1 random, 2 low in cycles 2-3.
    task automatic doFill(input int px, input int py, input int w, input int h,
                          input logic [DW-1:0] col, input int grantMode, input bit pokeStart);
        int n, cyc, grants, expDoneCyc, budget, wr0;
        bit gotDone, g;
        pushModel(px, py, w, h, col, n);
        wr0 = wrCount;
        budget = n * 4 + 20;
        @(posedge clk); #1;
        start = 1'b1;
        x0 = 6'(px); y0 = 5'(py); rectWidth = 7'(w); rectHeight = 6'(h); colour = col;
        grant = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 6'($urandom); y0 = 5'($urandom);
        rectWidth = 7'($urandom); rectHeight = 6'($urandom); colour = DW'($urandom);
        cyc = 1; grants = 0; gotDone = 0;
        expDoneCyc = (n == 0) ? 1 : -1;
        while (!gotDone && cyc < budget) begin
            case (grantMode)
                0: g = 1'b1;
                1: g = ($urandom_range(0, 3) != 0);
                default: g = !(cyc == 2 || cyc == 3);
            endcase
            grant = g;
            if (pokeStart && cyc == 2) begin
                start = 1'b1;
                colour = ~col;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (g && expDoneCyc < 0) begin
                grants++;
                if (grants == n) expDoneCyc = cyc + 1;
            end
            if (grantMode == 2 && (cyc == 2 || cyc == 3))
                check("stall_addr_hold", int'(fbAddress), 1);
            if (done) begin
                gotDone = 1;
                check("done_cycle", cyc, expDoneCyc);
                check("busy_with_done", int'(busy), 1);
            end else begin
                check("busy_during_fill", int'(busy), 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!gotDone) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("queue_empty", exp_q.size(), 0);
        check("write_count", wrCount - wr0, n);
        exp_q.delete();
    endtask

    initial begin
        int n;
        nReset = 1'b0; start = 1'b0; grant = 1'b0;
        x0 = '0; y0 = '0; rectWidth = '0; rectHeight = '0; colour = '0;
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_we", int'(fbWriteEnable), 0);
        check("reset_addr", int'(fbAddress), 0);
        check("reset_data", int'(fbData), 0);
        @(posedge clk); #1;
        nReset = 1'b1;

        doFill(1, 1, 2, 2, 9'h1FF, 0, 0);    // basic: 65,66,129,130
        doFill(62, 31, 4, 3, 9'h0A5, 0, 0);  // clipped: 2046,2047
        doFill(5, 5, 0, 5, 9'h033, 0, 0);    // empty width
        doFill(7, 3, 9, 0, 9'h044, 0, 0);    // empty height
        doFill(0, 0, 3, 1, 9'h111, 2, 0);    // grant stall
        doFill(10, 4, 2, 2, 9'h0F0, 0, 1);   // start while busy
        doFill(0, 0, 64, 32, 9'h155, 0, 0);  // full screen
        doFill(63, 0, 1, 32, 9'h0C3, 1, 0);  // last column, random grant

        // Asynchronous reset after two writes of a 2x2 fill.
        pushModel(1, 1, 2, 2, 9'h1AA, n);
        @(posedge clk); #1;
        start = 1'b1; x0 = 6'd1; y0 = 5'd1; rectWidth = 7'd2; rectHeight = 6'd2;
        colour = 9'h1AA; grant = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("pre_reset_busy", int'(busy), 1);
        nReset = 1'b0;
        #1;
        check("async_reset_we", int'(fbWriteEnable), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        check("reset_left_two", exp_q.size(), 2);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_in_reset", int'(done), 0);
        end
        @(posedge clk); #1;
        nReset = 1'b1;
        doFill(1, 1, 2, 2, 9'h1FF, 0, 0);

        for (int i = 0; i < 30; i++) begin
            doFill($urandom_range(0, 63), $urandom_range(0, 31),
                   $urandom_range(0, 20), $urandom_range(0, 10),
                   DW'($urandom), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
